// File: rtl/tt_rom_stream_wrapper.sv
// ROM project slot: registered random read or auto-incrementing valid/ready stream.
// Latency: random read 2 enabled clocks iw->ow; stream inserts one bubble per accepted word.
// Backpressure: word, valid and last hold while registered ready is low; ena=0 freezes every register.
module tt_rom_stream_wrapper #(
    parameter int    IO_W     = 8,
    parameter int    DEPTH    = 256,
    parameter int    ADDR_W   = $clog2(DEPTH),
    parameter string ROM_FILE = "chip_rom.hex"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [2*IO_W-1:0] iw,
    output logic [3*IO_W-1:0] ow
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DONE   = 3'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [IO_W-1:0] rom [DEPTH];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_word
            assign rom[i] = IO_W'(i) ^ IO_W'(8'hA5);
        end
    endgenerate

    logic [IO_W-1:0]   ui_q;
    logic [IO_W-1:0]   uio_q;
    logic              start_qq;
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [IO_W-1:0]   data;
    logic              valid;
    logic              last;
    logic              oe_on;

    logic [ADDR_W-1:0] addr_q;
    logic              mode_q;
    logic              start_q;
    logic              ready_q;
    logic              start_edge;
    logic              unused_in;

    assign addr_q     = ui_q[ADDR_W-1:0];
    assign mode_q     = uio_q[0];
    assign start_q    = uio_q[1];
    assign ready_q    = uio_q[2];
    assign start_edge = start_q & ~start_qq;
    assign unused_in  = &{1'b0, ui_q, uio_q};

    assign ow = {oe_on ? {{(IO_W-3){1'b1}}, 3'b000} : {IO_W{1'b0}},
                 IO_W'({state, last, valid, 3'b000}),
                 data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_q     <= '0;
            uio_q    <= '0;
            start_qq <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            data     <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
            oe_on    <= 1'b0;
        end else if (ena) begin
            ui_q     <= iw[IO_W-1:0];
            uio_q    <= iw[2*IO_W-1:IO_W];
            start_qq <= start_q;
            oe_on    <= 1'b1;
            case (state)
                IDLE: begin
                    data  <= rom[addr_q];
                    valid <= 1'b0;
                    last  <= 1'b0;
                    if (start_edge && mode_q) begin
                        cnt   <= addr_q;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!mode_q) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        last  <= 1'b0;
                    end else begin
                        data  <= rom[cnt];
                        valid <= 1'b1;
                        last  <= (cnt == LAST_ADDR);
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (!mode_q) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        last  <= 1'b0;
                    end else if (valid && ready_q) begin
                        valid <= 1'b0;
                        last  <= 1'b0;
                        if (last) state <= DONE;
                        else      cnt   <= cnt + 1'b1;
                    end else if (!valid) begin
                        data  <= rom[cnt];
                        valid <= 1'b1;
                        last  <= (cnt == LAST_ADDR);
                    end
                end
                DONE: begin
                    if (!start_q) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_rom_stream_wrapper.sv
// Scoreboard bench for tt_rom_stream_wrapper with the addr ^ 0xA5 ROM image.
module tb_tt_rom_stream_wrapper;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena   = 1'b1;
  logic [7:0]  ui    = 8'h00;
  logic        mode  = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] iw;
  logic [23:0] ow;

  assign iw = {5'b00000, ready, start, mode, ui};

  tt_rom_stream_wrapper #(
    .IO_W    (8),
    .DEPTH   (256),
    .ADDR_W  (8),
    .ROM_FILE("")
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .iw   (iw),
    .ow   (ow)
  );

  always #5 clk = ~clk;

  wire [7:0] uo      = ow[7:0];
  wire [7:0] uio_out = ow[15:8];
  wire [7:0] oe      = ow[23:16];
  wire       vld     = ow[11];
  wire       lst     = ow[12];
  wire [2:0] st      = ow[15:13];

  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic       rq_m = 1'b0;
  logic       mq_m = 1'b0;

  function automatic logic [7:0] rom_m(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // One clock; records {last,data} of any word the handshake accepts at this edge.
  task automatic tick();
    logic       acc;
    logic [8:0] word;
    logic       nr;
    logic       nm;
    acc  = ena && vld && rq_m && mq_m;
    word = {lst, uo};
    nr   = ena ? ready : rq_m;
    nm   = ena ? mode : mq_m;
    @(posedge clk);
    #1;
    rq_m = nr;
    mq_m = nm;
    if (acc) got_q.push_back(word);
  endtask

  task automatic start_stream(input logic [7:0] addr);
    int budget;
    mode  = 1'b1;
    ui    = addr;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    budget = 0;
    while (!vld && budget < 10) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (vld !== 1'b1) begin
      n_err++;
      $display("FAIL stream_start: valid=%b after %0d clocks, required 1", vld, budget);
    end
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ow !== 24'h0) begin n_err++; $display("FAIL reset_ow: ow=%h required 000000", ow); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (ow !== 24'h0) begin n_err++; $display("FAIL reset_hold: ow=%h required 000000", ow); end
    rst_n = 1'b1;
    n_cmp++;
    if (oe !== 8'h00) begin n_err++; $display("FAIL oe_before_clk: uio_oe=%h required 00", oe); end
    tick();
    n_cmp++;
    if (oe !== 8'hF8) begin n_err++; $display("FAIL oe_after_clk: uio_oe=%h required f8", oe); end
    n_cmp++;
    if (uio_out !== 8'h00) begin n_err++; $display("FAIL reset_uio_out: uio_out=%h required 00", uio_out); end
    n_cmp++;
    if (uo !== rom_m(8'h00)) begin n_err++; $display("FAIL reset_idle_data: uo_out=%h required %h", uo, rom_m(8'h00)); end
  endtask

  task automatic test_random();
    logic [8:0] e;
    mode = 1'b0;
    ui   = 8'h10;
    exp_q.push_back({1'b0, rom_m(8'h10)});
    tick();
    n_cmp++;
    if (uo !== 8'hA5) begin n_err++; $display("FAIL random_latency1: uo_out=%h required a5", uo); end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if ({lst, uo} !== e || uo !== 8'hB5) begin n_err++; $display("FAIL random_10: uo_out=%h required %h", uo, e[7:0]); end
    n_cmp++;
    if (vld !== 1'b0) begin n_err++; $display("FAIL random_valid: valid=%b required 0", vld); end
    ui = 8'hFF;
    exp_q.push_back({1'b0, rom_m(8'hFF)});
    tick();
    n_cmp++;
    if (uo !== 8'hB5) begin n_err++; $display("FAIL random_latency2: uo_out=%h required b5", uo); end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if ({lst, uo} !== e || uo !== 8'h5A) begin n_err++; $display("FAIL random_ff: uo_out=%h required %h", uo, e[7:0]); end
    n_cmp++;
    if ({vld, st} !== 4'b0_000) begin n_err++; $display("FAIL random_idle: valid=%b state=%0d required 0/0", vld, st); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] addrs[6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hC3, 8'hFE};
    logic [8:0] e;
    mode = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        ui = addrs[i];
        exp_q.push_back({1'b0, rom_m(addrs[i])});
      end
      tick();
      if (i >= 1) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({lst, uo} !== e || vld !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_%0d: last/data=%h valid=%b required %h/0", i, {lst, uo}, vld, e);
        end
      end
    end
  endtask

  task automatic test_stream_backpressure();
    int budget;
    logic [8:0] e;
    exp_q.delete();
    got_q.delete();
    ready = 1'b0;
    for (int a = 'hFC; a <= 'hFF; a++) exp_q.push_back({a == 'hFF, rom_m(8'(a))});
    start_stream(8'hFC);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({vld, lst, uo} !== {2'b10, exp_q[0][7:0]} || st !== 3'd2) begin
        n_err++;
        $display("FAIL bp_hold_%0d: valid=%b last=%b data=%h state=%0d required 1/0/%h/2", i, vld, lst, uo, st, exp_q[0][7:0]);
      end
      tick();
    end
    ready  = 1'b1;
    budget = 0;
    while (got_q.size() < 4 && budget < 40) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (got_q.size() != 4) begin n_err++; $display("FAIL bp_count: accepted %0d words required 4", got_q.size()); end
    n_cmp++;
    if (st !== 3'd3 || vld !== 1'b0) begin n_err++; $display("FAIL bp_done: state=%0d valid=%b required 3/0", st, vld); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin
        n_err++;
        $display("FAIL bp_word: missing word, required %h", e);
      end else if (got_q[0] !== e) begin
        n_err++;
        $display("FAIL bp_word: last/data=%h required %h", got_q.pop_front(), e);
      end else begin
        void'(got_q.pop_front());
      end
    end
    ready = 1'b0;
    tick();
    n_cmp++;
    if (st !== 3'd0) begin n_err++; $display("FAIL bp_idle: state=%0d required 0", st); end
  endtask

  task automatic test_ena_gating();
    int budget;
    int n_held;
    logic [23:0] snap;
    logic [8:0]  e;
    exp_q.delete();
    got_q.delete();
    ready = 1'b1;
    for (int a = 'hF0; a <= 'hFF; a++) exp_q.push_back({a == 'hFF, rom_m(8'(a))});
    start_stream(8'hF0);
    budget = 0;
    while (got_q.size() < 3 && budget < 20) begin
      tick();
      budget++;
    end
    snap   = ow;
    n_held = got_q.size();
    ena    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (ow !== snap || got_q.size() != n_held) begin
        n_err++;
        $display("FAIL ena_freeze_%0d: ow=%h words=%0d required %h/%0d", i, ow, got_q.size(), snap, n_held);
      end
    end
    ena    = 1'b1;
    budget = 0;
    while (got_q.size() < 16 && budget < 60) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (got_q.size() != 16) begin n_err++; $display("FAIL ena_count: accepted %0d words required 16", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin
        n_err++;
        $display("FAIL ena_word: missing word, required %h", e);
      end else if (got_q[0] !== e) begin
        n_err++;
        $display("FAIL ena_word: last/data=%h required %h", got_q.pop_front(), e);
      end else begin
        void'(got_q.pop_front());
      end
    end
    ready = 1'b0;
    tick();
    n_cmp++;
    if (st !== 3'd0) begin n_err++; $display("FAIL ena_idle: state=%0d required 0", st); end
  endtask

  task automatic test_abort_ignored_start();
    int budget;
    logic [8:0] e;
    exp_q.delete();
    got_q.delete();
    ready = 1'b1;
    exp_q.push_back({1'b0, rom_m(8'h1E)});
    exp_q.push_back({1'b0, rom_m(8'h1F)});
    start_stream(8'h1E);
    budget = 0;
    while (got_q.size() < 2 && budget < 20) begin
      tick();
      budget++;
    end
    ready  = 1'b0;
    budget = 0;
    while (!vld && budget < 5) begin
      tick();
      budget++;
    end
    n_cmp++;
    if ({vld, uo} !== {1'b1, rom_m(8'h20)}) begin n_err++; $display("FAIL abort_cnt20: valid=%b data=%h required 1/%h", vld, uo, rom_m(8'h20)); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({st, vld, uo} !== {3'd2, 1'b1, rom_m(8'h20)} || got_q.size() != 2) begin
      n_err++;
      $display("FAIL ignored_start: state=%0d valid=%b data=%h words=%0d required 2/1/%h/2", st, vld, uo, got_q.size(), rom_m(8'h20));
    end
    mode = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({st, vld, lst} !== 5'b000_0_0) begin n_err++; $display("FAIL abort_idle: state=%0d valid=%b last=%b required 0/0/0", st, vld, lst); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin
        n_err++;
        $display("FAIL abort_word: missing word, required %h", e);
      end else if (got_q[0] !== e) begin
        n_err++;
        $display("FAIL abort_word: last/data=%h required %h", got_q.pop_front(), e);
      end else begin
        void'(got_q.pop_front());
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_q.delete();
    got_q.delete();
    ready = 1'b0;
    start_stream(8'h40);
    n_cmp++;
    if (uo !== 8'hE5) begin n_err++; $display("FAIL simul_first: data=%h required e5", uo); end
    ready = 1'b1;
    mode  = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({st, vld} !== 4'b000_0 || got_q.size() != 0) begin
      n_err++;
      $display("FAIL simul_abort_wins: state=%0d valid=%b words=%0d required 0/0/0", st, vld, got_q.size());
    end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    exp_q.delete();
    got_q.delete();
    ready = 1'b0;
    start_stream(8'h80);
    n_cmp++;
    if ({vld, uo} !== 9'h125) begin n_err++; $display("FAIL areset_pre: valid=%b data=%h required 1/25", vld, uo); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ow !== 24'h0) begin n_err++; $display("FAIL areset_immediate: ow=%h required 000000", ow); end
    @(posedge clk);
    #1;
    mode  = 1'b0;
    rq_m  = 1'b0;
    mq_m  = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({oe, st, vld} !== {8'hF8, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL areset_release: uio_oe=%h state=%0d valid=%b required f8/0/0", oe, st, vld);
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_back_to_back();
    test_stream_backpressure();
    test_ena_gating();
    test_abort_ignored_start();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1);
  end

endmodule
